riscv_regfile_mp: RTL and testbench

- Parametrised multi-read-port register file for the RISC-V core; the next generation of the single-write, two-read pipeline register file.
- Sits between the decode stage, which reads operands, and the write-back stage, which writes results.
- Adds the following over the previous generation:
  - configurable data width, depth, read-port count and write-back address delay;
  - hardwired-zero x0;
  - same-cycle write-to-read bypass;
  - per-port read enables;
  - a synchronous clear.

---
 rtl/riscv_regfile_mp.sv | 100 ++++++++++
 tb/tb_riscv_regfile_mp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_regfile_mp.sv
// Multi-read-port RISC-V register file: hardwired-zero x0, delayed write-back address,
// optional same-edge write-to-read bypass, per-port read enables and a synchronous clear.
module riscv_regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned WB_DELAY = 3,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic                              wr_en_i,
    input  logic [$clog2(NREGS)-1:0]          wr_addr_i,
    input  logic [XLEN-1:0]                   wr_data_i,
    input  logic [NRD-1:0]                    rd_en_i,
    input  logic [NRD*$clog2(NREGS)-1:0]      rd_addr_i,
    output logic [NRD*XLEN-1:0]               rd_data_o
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [AW-1:0]   waddr_eff;
    logic            wr_fire;
    logic [XLEN-1:0] regs_q [NREGS];

    // Write-back address arrives WB_DELAY cycles ahead of its data; delay it to line up.
    generate
        if (WB_DELAY == 0) begin : g_no_delay
            assign waddr_eff = wr_addr_i;
        end else begin : g_delay
            logic [AW-1:0] pipe_q [WB_DELAY];

            // Unconditional shift register; cleared only by reset, never by clear_i.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int i = 0; i < int'(WB_DELAY); i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= wr_addr_i;
                    for (int i = 1; i < int'(WB_DELAY); i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign waddr_eff = pipe_q[WB_DELAY-1];
        end
    endgenerate

    // x0 is never written, so it stays at its reset value of zero.
    assign wr_fire = wr_en_i && !clear_i && (waddr_eff != '0);

    // Architectural state: clear wipes everything and suppresses the same-edge write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else if (wr_fire) begin
            regs_q[waddr_eff] <= wr_data_i;
        end
    end

    // One registered read path per port; identical logic guarantees identical data per address.
    generate
        for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
            logic [AW-1:0]   rd_addr;
            logic [XLEN-1:0] rd_d;
            logic [XLEN-1:0] rd_q;

            assign rd_addr = rd_addr_i[k*AW +: AW];

            // Next read word: clear beats x0, x0 beats bypass, bypass beats stored value.
            always_comb begin
                rd_d = rd_q;
                if (rd_en_i[k]) begin
                    if (clear_i) begin
                        rd_d = '0;
                    end else if (rd_addr == '0) begin
                        rd_d = '0;
                    end else if (BYPASS && wr_en_i && (waddr_eff == rd_addr)) begin
                        rd_d = wr_data_i;
                    end else begin
                        rd_d = regs_q[rd_addr];
                    end
                end
            end

            // Output register; holds while the port is disabled.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_d;
                end
            end

            assign rd_data_o[k*XLEN +: XLEN] = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Scoreboarded bench: two DUTs (bypass on/off) share stimulus; a reference model predicts
// every output word and a monitor compares after each clock edge.
module tb_riscv_regfile_mp;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int NRD      = 2;
    localparam int WB_DELAY = 3;
    localparam int AW       = $clog2(NREGS);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                clear = 1'b0;
    logic                we = 1'b0;
    logic [AW-1:0]       wa = '0;
    logic [XLEN-1:0]     wd = '0;
    logic [NRD-1:0]      ren = '0;
    logic [NRD*AW-1:0]   ra = '0;
    logic [NRD*XLEN-1:0] rd_b;
    logic [NRD*XLEN-1:0] rd_n;

    always #5 clk = ~clk;

    riscv_regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .WB_DELAY(WB_DELAY), .BYPASS(1'b1)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .wr_en_i(we), .wr_addr_i(wa),
        .wr_data_i(wd), .rd_en_i(ren), .rd_addr_i(ra), .rd_data_o(rd_b)
    );

    riscv_regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .WB_DELAY(WB_DELAY), .BYPASS(1'b0)
    ) dut_n (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .wr_en_i(we), .wr_addr_i(wa),
        .wr_data_i(wd), .rd_en_i(ren), .rd_addr_i(ra), .rd_data_o(rd_n)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [XLEN-1:0]     mem [NREGS];
    logic [AW-1:0]       hist [$];       // addresses presented in past cycles, newest first
    logic [XLEN-1:0]     out_b [NRD];
    logic [XLEN-1:0]     out_n [NRD];
    logic [NRD*XLEN-1:0] exp_b_q [$];
    logic [NRD*XLEN-1:0] exp_n_q [$];

    function automatic logic [NRD*AW-1:0] addrs(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        return {a1, a0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mem[i] = '0;
        hist = {};
        for (int i = 0; i < WB_DELAY; i++) hist.push_back('0);
        for (int k = 0; k < NRD; k++) begin
            out_b[k] = '0;
            out_n[k] = '0;
        end
    endtask

    task automatic check_word(input string name, input logic [XLEN-1:0] act,
                              input logic [XLEN-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge, advance the model, queue the expected outputs.
    task automatic drive(input logic e, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                         input logic [NRD-1:0] re, input logic [NRD*AW-1:0] ras,
                         input logic c);
        logic [AW-1:0]       eff;
        logic [AW-1:0]       addr;
        logic [NRD*XLEN-1:0] vb;
        logic [NRD*XLEN-1:0] vn;
        @(negedge clk);
        we = e; wa = a; wd = d; ren = re; ra = ras; clear = c;
        eff = (hist.size() > 0) ? hist[hist.size()-1] : a;
        for (int k = 0; k < NRD; k++) begin
            if (re[k]) begin
                addr = ras[k*AW +: AW];
                if (c || addr == 0) begin
                    out_b[k] = '0;
                    out_n[k] = '0;
                end else begin
                    out_n[k] = mem[addr];
                    out_b[k] = (e && eff == addr) ? d : mem[addr];
                end
            end
            vb[k*XLEN +: XLEN] = out_b[k];
            vn[k*XLEN +: XLEN] = out_n[k];
        end
        if (c) begin
            for (int i = 0; i < NREGS; i++) mem[i] = '0;
        end else if (e && eff != 0) begin
            mem[eff] = d;
        end
        if (hist.size() > 0) begin
            hist.push_front(a);
            void'(hist.pop_back());
        end
        exp_b_q.push_back(vb);
        exp_n_q.push_back(vn);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int k = 0; k < NRD; k++) begin
            check_word("async_reset_byp", rd_b[k*XLEN +: XLEN], '0);
            check_word("async_reset_nobyp", rd_n[k*XLEN +: XLEN], '0);
        end
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: after every edge, compare DUT outputs against the oldest queued expectation.
    initial begin
        logic [NRD*XLEN-1:0] eb;
        logic [NRD*XLEN-1:0] en;
        forever begin
            @(posedge clk);
            #1;
            if (exp_b_q.size() > 0) begin
                eb = exp_b_q.pop_front();
                en = exp_n_q.pop_front();
                for (int k = 0; k < NRD; k++) begin
                    check_word($sformatf("bypass_port%0d", k), rd_b[k*XLEN +: XLEN],
                               eb[k*XLEN +: XLEN]);
                    check_word($sformatf("nobypass_port%0d", k), rd_n[k*XLEN +: XLEN],
                               en[k*XLEN +: XLEN]);
                end
            end
        end
    end

    initial begin
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Delayed write: x6 presented at t-1 takes the t+2 strobe, x5 at t takes t+3.
        drive(1'b0, 5'd6, '0, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd5, '0, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd0, '0, 2'b00, '0, 1'b0);
        drive(1'b1, 5'd0, 32'h0000CAFE, 2'b00, '0, 1'b0);
        drive(1'b1, 5'd0, 32'h12345678, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd0, '0, 2'b11, addrs(5'd6, 5'd5), 1'b0);
        idle();

        // Same-edge write and dual read of x7, then a follow-up read.
        drive(1'b0, 5'd7, '0, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd0, '0, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd0, '0, 2'b00, '0, 1'b0);
        drive(1'b1, 5'd0, 32'hA5A5A5A5, 2'b11, addrs(5'd7, 5'd7), 1'b0);
        drive(1'b0, 5'd0, '0, 2'b11, addrs(5'd7, 5'd7), 1'b0);

        // Read-enable hold on port 0.
        drive(1'b0, 5'd3, '0, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd4, '0, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd0, '0, 2'b00, '0, 1'b0);
        drive(1'b1, 5'd0, 32'h11, 2'b00, '0, 1'b0);
        drive(1'b1, 5'd0, 32'h22, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd0, '0, 2'b01, addrs(5'd3, 5'd0), 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 5'd0, '0, 2'b00, addrs(5'd4, 5'd0), 1'b0);
        drive(1'b0, 5'd0, '0, 2'b01, addrs(5'd4, 5'd0), 1'b0);
        idle();

        // Randomised traffic with occasional clears and resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(299) == 0) do_reset();
            drive(1'($urandom), AW'($urandom), $urandom, NRD'($urandom),
                  (NRD*AW)'($urandom), ($urandom_range(49) == 0));
        end

        // Reset mid-operation with non-zero outputs, then a write to x0.
        drive(1'b0, 5'd0, '0, 2'b11, addrs(5'd7, 5'd5), 1'b0);
        do_reset();
        drive(1'b0, 5'd0, '0, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd0, '0, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd0, '0, 2'b00, '0, 1'b0);
        drive(1'b1, 5'd0, 32'hDEADBEEF, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd0, '0, 2'b01, addrs(5'd0, 5'd0), 1'b0);

        // Fill x1..x31 with their index, then clear alongside a write of 0xFF to x9.
        for (int i = 1; i < 35; i++) begin
            drive((i >= 4), (i < 32) ? AW'(i) : AW'(0), XLEN'(i - 3), 2'b00, '0, 1'b0);
        end
        drive(1'b0, 5'd9, '0, 2'b11, addrs(5'd9, 5'd31), 1'b0);
        drive(1'b0, 5'd0, '0, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd0, '0, 2'b00, '0, 1'b0);
        drive(1'b1, 5'd0, 32'hFF, 2'b11, addrs(5'd9, 5'd9), 1'b1);
        for (int i = 0; i < NREGS; i += 2) begin
            drive(1'b0, 5'd0, '0, 2'b11, addrs(AW'(i), AW'(i + 1)), 1'b0);
        end

        // Address 10 presented, reset for one cycle, write strobe arrives two cycles later.
        drive(1'b0, 5'd10, '0, 2'b00, '0, 1'b0);
        do_reset();
        drive(1'b0, 5'd0, '0, 2'b00, '0, 1'b0);
        drive(1'b1, 5'd0, 32'h55, 2'b00, '0, 1'b0);
        drive(1'b0, 5'd0, '0, 2'b11, addrs(5'd10, 5'd0), 1'b0);
        for (int i = 0; i < NREGS; i += 2) begin
            drive(1'b0, 5'd0, '0, 2'b11, addrs(AW'(i), AW'(i + 1)), 1'b0);
        end

        // Drain: every queued expectation must have been consumed.
        @(posedge clk);
        #2;
        n_vec++;
        if (exp_b_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_b_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
